// File: rtl/actuator_wb_regs_pkg.sv
// Register map, bit positions and command type shared by the actuator Wishbone
// register block and its command FIFO.
package actuator_wb_pkg;
  localparam logic [11:0] OFF_CTRL   = 12'h000;
  localparam logic [11:0] OFF_STATUS = 12'h004;
  localparam logic [11:0] OFF_CMD    = 12'h008;
  localparam logic [11:0] OFF_CSTAT  = 12'h00C;
  localparam logic [11:0] OFF_IRQ    = 12'h010;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_LEVEL_LSB = 4;
  localparam int STAT_LEVEL_W   = 5;
  localparam int STAT_OVERFLOW  = 12;

  localparam int IRQ_DONE = 0;

  typedef logic [31:0] cmd_t;
endpackage

// File: rtl/actuator_wb_regs_if.sv
// Wishbone classic slave bus as seen by the user project area.
interface actuator_wb_regs_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_dat_o, wbs_ack_o);
  modport slave  (input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_dat_o, wbs_ack_o);
endinterface

// File: rtl/actuator_wb_regs_cmd_fifo.sv
// Command FIFO; a push into a full FIFO is accepted when a pop lands on the same edge.
module actuator_cmd_fifo
  import actuator_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  cmd_t       din,
  output cmd_t       dout,
  output logic       empty,
  output logic       full,
  output logic [4:0] level
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [4:0]    count;
  logic          push_ok, pop_ok;

  assign empty   = (count == 5'd0);
  assign full    = (count == 5'(DEPTH));
  assign level   = count;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rp];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (pop_ok) rp <= rp + AW'(1);
      count <= count + 5'(push_ok) - 5'(pop_ok);
    end
  end
endmodule

// File: rtl/actuator_wb_regs.sv
// Wishbone register front end for the actuator controller: CTRL/STATUS/CMD/CSTAT/IRQ
// with a command FIFO streaming to the controller and a drain-complete interrupt.
module actuator_wb_regs
  import actuator_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  actuator_wb_regs_if.slave  wbs,
  output logic               cmd_valid_o,
  output cmd_t               cmd_data_o,
  input  logic               cmd_ready_i,
  input  logic [31:0]        status_i,
  output logic               irq_o
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  logic [0:0]  state;
  logic        enable, irq_en, overflow, done_pending, irq_q;
  logic [31:0] rdata, dat_q;
  logic [11:0] woff;
  logic        accept, in_win, wr_acc, rd_acc;
  logic        ctrl_wr, flush, push, pop, drain, push_drop, ovf_clr, irq_clr;
  logic        empty, full;
  logic [4:0]  level;
  cmd_t        head;
  logic        unused_adr;

  assign unused_adr = ^wbs.wbs_adr_i[1:0];

  assign accept = wbs.wbs_cyc_i & wbs.wbs_stb_i & (state == S_IDLE);
  assign in_win = (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign woff   = {wbs.wbs_adr_i[11:2], 2'b00};
  assign wr_acc = accept & in_win & wbs.wbs_we_i;
  assign rd_acc = accept & in_win & ~wbs.wbs_we_i;

  assign ctrl_wr = wr_acc & (woff == OFF_CTRL) & wbs.wbs_sel_i[0];
  assign flush   = ctrl_wr & wbs.wbs_dat_i[CTRL_FLUSH];
  assign push    = wr_acc & (woff == OFF_CMD) & (wbs.wbs_sel_i == 4'hF);
  assign ovf_clr = wr_acc & (woff == OFF_STATUS) & wbs.wbs_dat_i[STAT_OVERFLOW];
  assign irq_clr = wr_acc & (woff == OFF_IRQ) & wbs.wbs_dat_i[IRQ_DONE];

  assign cmd_valid_o = enable & ~empty;
  assign cmd_data_o  = head;
  assign pop         = cmd_valid_o & cmd_ready_i;
  assign push_drop   = push & full & ~pop;
  // A push alongside the last pop keeps one entry, so the FIFO never drains.
  assign drain       = pop & ~push & ~flush & (level == 5'd1);

  actuator_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wbs.wbs_dat_i),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  always_comb begin
    rdata = '0;
    if (rd_acc) begin
      case (woff)
        OFF_CTRL: begin
          rdata[CTRL_ENABLE] = enable;
          rdata[CTRL_IRQ_EN] = irq_en;
        end
        OFF_STATUS: begin
          rdata[STAT_EMPTY]                            = empty;
          rdata[STAT_FULL]                             = full;
          rdata[STAT_LEVEL_LSB +: STAT_LEVEL_W]        = level;
          rdata[STAT_OVERFLOW]                         = overflow;
        end
        OFF_CSTAT: rdata = status_i;
        OFF_IRQ:   rdata[IRQ_DONE] = done_pending;
        default:   rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= S_IDLE;
      dat_q        <= '0;
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      overflow     <= 1'b0;
      done_pending <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state <= accept ? S_ACK : S_IDLE;
      dat_q <= rdata;
      if (ctrl_wr) begin
        enable <= wbs.wbs_dat_i[CTRL_ENABLE];
        irq_en <= wbs.wbs_dat_i[CTRL_IRQ_EN];
      end
      if (push_drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      // Set wins over a same-cycle W1C clear.
      if (drain)        done_pending <= 1'b1;
      else if (irq_clr) done_pending <= 1'b0;
      irq_q <= done_pending & irq_en;
    end
  end

  assign wbs.wbs_ack_o = (state == S_ACK);
  assign wbs.wbs_dat_o = dat_q;
  assign irq_o         = irq_q;
endmodule

// File: tb/tb_actuator_wb_regs.sv
// Directed bench for actuator_wb_regs: queue-based reference model compared every
// cycle, plus literal expectations taken from the register map rules.
module tb_actuator_wb_regs;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_ready = 1'b0;
  logic [31:0] status_w = 32'h1234_5678;
  logic        cmd_valid, irq;
  logic [31:0] cmd_data;

  actuator_wb_regs_if bus ();

  actuator_wb_regs #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (bus),
    .cmd_valid_o (cmd_valid),
    .cmd_data_o  (cmd_data),
    .cmd_ready_i (cmd_ready),
    .status_i    (status_w),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_ack = 1'b0, m_irq = 1'b0, m_en = 1'b0, m_ien = 1'b0, m_ovf = 1'b0, m_dp = 1'b0;
  logic [31:0] m_dat = '0;
  logic [31:0] mq[$];
  logic        m_acc, m_pop, m_hit, m_push;
  logic [11:0] m_off;
  logic [31:0] m_rv;
  int          m_n;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ack = 0; m_dat = 0; m_irq = 0; m_en = 0; m_ien = 0; m_ovf = 0; m_dp = 0;
      mq.delete();
    end else begin
      m_acc = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack;
      m_hit = (bus.wbs_adr_i >= BASE) && (bus.wbs_adr_i < BASE + 32'h1000);
      m_off = {bus.wbs_adr_i[11:2], 2'b00};
      m_n   = mq.size();
      m_rv  = 0;
      if (m_acc && m_hit && !bus.wbs_we_i) begin
        if (m_off == 12'h000) m_rv = {30'd0, m_ien, m_en};
        if (m_off == 12'h004) m_rv = (32'(m_ovf) << 12) | (32'(m_n) << 4)
                                     | (32'(m_n == DEPTH) << 1) | 32'(m_n == 0);
        if (m_off == 12'h00C) m_rv = status_w;
        if (m_off == 12'h010) m_rv = {31'd0, m_dp};
      end
      m_pop  = m_en && (m_n != 0) && cmd_ready;
      m_push = m_acc && m_hit && bus.wbs_we_i && m_off == 12'h008 && bus.wbs_sel_i == 4'hF;
      m_irq  = m_dp && m_ien;
      m_ack  = m_acc;
      m_dat  = m_rv;
      if (m_acc && m_hit && bus.wbs_we_i) begin
        if (m_off == 12'h004 && bus.wbs_dat_i[12]) m_ovf = 0;
        if (m_off == 12'h010 && bus.wbs_dat_i[0])  m_dp = 0;
      end
      if (m_acc && m_hit && bus.wbs_we_i && m_off == 12'h000 && bus.wbs_sel_i[0]) begin
        m_en  = bus.wbs_dat_i[0];
        m_ien = bus.wbs_dat_i[1];
        if (bus.wbs_dat_i[2]) mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          if (m_n < DEPTH || m_pop) mq.push_back(bus.wbs_dat_i);
          else m_ovf = 1;
        end
        if (m_pop && mq.size() == 0) m_dp = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack",       {31'd0, bus.wbs_ack_o}, {31'd0, m_ack});
      chk("dat_o",     bus.wbs_dat_o, m_dat);
      chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_en && mq.size() != 0});
      chk("cmd_data",  cmd_data, (mq.size() != 0) ? mq[0] : 32'd0);
      chk("irq_o",     {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // ---------------- stream / irq monitor ----------------
  int          cnt = 0;
  int          last_pop = -100;
  int          irq_rise = -1;
  logic        irq_d = 1'b0;
  logic [31:0] got[$];

  always @(posedge clk) cnt <= cnt + 1;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      got.push_back(cmd_data);
      last_pop = cnt;
    end
    if (irq && !irq_d) irq_rise = cnt;
    irq_d = irq;
  end

  // ---------------- bus driver ----------------
  task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit rdy_pulse,
                        output logic [31:0] rd, output logic ackd);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
    if (rdy_pulse) cmd_ready = 1;
    @(posedge clk); #1;
    rd = bus.wbs_dat_o; ackd = bus.wbs_ack_o;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    if (rdy_pulse) cmd_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input string nm, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel = 4'hF);
    logic [31:0] r; logic a;
    access(1'b1, adr, dat, sel, 1'b0, r, a);
    chk({nm, "_ack"}, {31'd0, a}, 32'd1);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r; logic a;
    access(1'b0, adr, 32'd0, 4'hF, 1'b0, r, a);
    chk({nm, "_ack"}, {31'd0, a}, 32'd1);
    chk(nm, r, exp);
  endtask

  logic [31:0] exp_a[3] = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
  logic [31:0] exp_b[4] = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hC000_0000};

  initial begin
    logic [31:0] r; logic a;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",   {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_dat",   bus.wbs_dat_o, 32'd0);
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_data",  cmd_data, 32'd0);
    chk("rst_irq",   {31'd0, irq}, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    rd_chk("status_reset", BASE + 32'h4, 32'h0000_0001);
    chk("valid_idle", {31'd0, cmd_valid}, 32'd0);

    // Three commands held while disabled, then released.
    for (int i = 0; i < 3; i++) wr("cmd_a", BASE + 32'h8, exp_a[i]);
    chk("valid_disabled", {31'd0, cmd_valid}, 32'd0);
    rd_chk("status_lvl3", BASE + 32'h4, 32'h0000_0030);
    cmd_ready = 1;
    got.delete();
    irq_rise = -1;
    wr("ctrl_en", BASE, 32'h3);
    for (int i = 0; i < 20 && irq_rise < 0; i++) @(posedge clk);
    #1;
    chk("stream_cnt", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("stream_word", got[i], exp_a[i]);
    chk("irq_latency", 32'(irq_rise - last_pop), 32'd2);
    rd_chk("irq_pend", BASE + 32'h10, 32'h1);
    wr("irq_w1c", BASE + 32'h10, 32'h1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd_chk("irq_after", BASE + 32'h10, 32'h0);

    // Overflow on the fifth push.
    cmd_ready = 0;
    wr("ctrl_off", BASE, 32'h0);
    for (int i = 0; i < 5; i++) wr("cmd_b", BASE + 32'h8, 32'hB000_0000 + 32'(i));
    rd_chk("status_ovf", BASE + 32'h4, 32'h0000_1042);
    wr("ovf_clr", BASE + 32'h4, 32'h0000_1000);
    rd_chk("status_clr", BASE + 32'h4, 32'h0000_0042);

    // Push into a full FIFO on the same edge as a pop.
    wr("ctrl_en1", BASE, 32'h1);
    access(1'b1, BASE + 32'h8, 32'hC000_0000, 4'hF, 1'b1, r, a);
    chk("pushpop_ack", {31'd0, a}, 32'd1);
    rd_chk("status_pushpop", BASE + 32'h4, 32'h0000_0042);
    got.delete();
    cmd_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    cmd_ready = 0;
    chk("drain_cnt", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("drain_word", got[i], exp_b[i]);

    // Partial-sel CMD write and out-of-window accesses are acked with no effect.
    wr("cmd_sel3", BASE + 32'h8, 32'hEEEE_0000, 4'h3);
    wr("oow_wr", BASE + 32'h1008, 32'hEEEE_0001);
    rd_chk("status_unch", BASE + 32'h4, 32'h0000_0001);
    rd_chk("oow_rd", BASE + 32'h100C, 32'h0);
    rd_chk("cstat", BASE + 32'hC, 32'h1234_5678);
    rd_chk("cmd_rd", BASE + 32'h8, 32'h0);

    // Flush empties the FIFO without raising done_pending.
    wr("irq_w1c2", BASE + 32'h10, 32'h1);
    wr("ctrl_off2", BASE, 32'h0);
    wr("cmd_d0", BASE + 32'h8, 32'hD000_0000);
    wr("cmd_d1", BASE + 32'h8, 32'hD000_0001);
    rd_chk("status_lvl2", BASE + 32'h4, 32'h0000_0020);
    wr("flush", BASE, 32'h4);
    rd_chk("status_flushed", BASE + 32'h4, 32'h0000_0001);
    rd_chk("ctrl_flush_rd", BASE, 32'h0);
    rd_chk("irq_noflush", BASE + 32'h10, 32'h0);

    // Reset while a CTRL write is pending its ack.
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
    bus.wbs_adr_i = BASE; bus.wbs_dat_i = 32'h3; bus.wbs_sel_i = 4'hF;
    rst = 1;
    @(posedge clk); #1;
    chk("rst_abort_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    rst = 0;
    @(posedge clk); #1;
    rd_chk("ctrl_after_rst", BASE, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/actuator_wb_regs.md
# actuator_wb_regs

Wishbone classic responder in the user project area that answers the management SoC's Wishbone bus on `wbs_*` at word granularity, with one access per two cycles minimum. It exposes control, status and interrupt registers, plus a command FIFO. The FIFO feeds 32-bit actuator commands to `actuator_driver_controller` over a valid/ready stream. It also reflects the controller's status word back to firmware and raises a drain-complete interrupt on `user_irq`.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: window base; window is `BASE_ADDR` .. `BASE_ADDR`+0xFFF.
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, range 2..16.
- `wb_clk_i` input 1: sole clock.
- `wb_rst_i` input 1: reset, synchronous, active-high.
- `wbs_cyc_i` input 1: bus cycle.
- `wbs_stb_i` input 1: strobe.
- `wbs_we_i` input 1: 1 = write.
- `wbs_sel_i` input 4: byte enables.
- `wbs_adr_i` input 32: byte address.
- `wbs_dat_i` input 32: write data.
- `wbs_dat_o` output 32: read data.
- `wbs_ack_o` output 1: acknowledge.
- `cmd_valid_o` output 1: command available to controller.
- `cmd_data_o` output 32: FIFO head.
- `cmd_ready_i` input 1: controller accepts head.
- `status_i` input 32: controller status word.
- `irq_o` output 1: to `user_irq[0]`.

## Operation
- **Access acceptance:** an access is accepted in cycle N when `cyc & stb & !ack`.
- **Write commit:** write side effects commit at the edge ending cycle N.
- **Acknowledge:** `ack` is high for exactly cycle N+1.
- **Read data:** `dat_o` is valid in cycle N+1 and 0 in all other cycles.
- **Outside the window:** accesses are still acked, reads return 0, writes are ignored.
- **Unmapped offsets inside the window:** same behaviour as outside the window.
- **Register map (offset in window):**
  - 0x00 CTRL RW:
    - bit0 `enable`.
    - bit1 `irq_en`.
    - bit2 `flush`: write-1 self-clearing, reads 0.
    - Only byte lane 0 is honoured, gated by `sel[0]`.
  - 0x04 STATUS RO:
    - bit0 `empty`.
    - bit1 `full`.
    - bits[8:4] `level`.
    - bit12 `overflow`: sticky; write 1 to bit12 clears it (W1C is the sole write effect at 0x04).
  - 0x08 CMD WO:
    - A write with `sel`==4'hF pushes `dat_i`.
    - A write with any other `sel` is ignored.
    - Reads return 0.
  - 0x0C CSTAT RO: `status_i`, sampled in cycle N.
  - 0x10 IRQ:
    - bit0 `done_pending`, W1C.
- **FIFO push/pop:**
  - Pop occurs on `cmd_valid_o & cmd_ready_i`.
  - `cmd_valid_o` = `enable & !empty`.
  - `cmd_data_o` = head entry, 0 when empty.
- **Full:**
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped, FIFO contents are unchanged, and `overflow` is set.
- **Flush:** empties the FIFO and discards any same-cycle pop; `overflow` is unaffected.
- **`enable` = 0:** holds the FIFO contents; pushes are still accepted.
- **Pointer wrap:** pointers wrap modulo `FIFO_DEPTH`; `level` ranges 0..`FIFO_DEPTH`.
- **Interrupt:**
  - `done_pending` is set when a pop takes `level` from 1 to 0.
  - A flush does not set it.
  - Set dominates a same-cycle W1C clear.
  - `irq_o` = `done_pending & irq_en`, registered.

## Timing
- **Reset values (registered at the next edge with `wb_rst_i` high):**
  - `wbs_ack_o`=0, `wbs_dat_o`=0.
  - `cmd_valid_o`=0, `cmd_data_o`=0.
  - `irq_o`=0.
  - CTRL=0, `overflow`=0, `done_pending`=0.
  - FIFO empty.
- **Reset mid-access:** the access is aborted with no ack; no side effects commit.
- **Bus latency:** 1 cycle from accept to ack. Back-to-back strobes are served every second cycle.
- **Command path latency:**
  - A CMD push in cycle N makes `cmd_valid_o` high in N+1 if `enable`.
  - A pop in cycle M presents the next head in M+1.
- **`irq_o` latency:** rises 2 cycles after the draining pop (`done_pending` in M+1, `irq_o` in M+2).
- **Dropped strobe:** `cyc` or `stb` dropping during cycle N+1 does not cancel the ack.

## Structure
- **Package `actuator_wb_pkg`:**
  - Register offsets: `OFF_CTRL`, `OFF_STATUS`, `OFF_CMD`, `OFF_CSTAT`, `OFF_IRQ`.
  - CTRL/STATUS bit-position constants.
  - `cmd_t` as a 32-bit typedef.
- **Sub-module `actuator_cmd_fifo`:**
  - Parameterised depth.
  - Ports: `push`, `pop`, `flush`, `din`, `dout`, `empty`, `full`, `level`.
  - Same-cycle push+pop is allowed when full.
- **Top level:** keeps the bus FSM, registers and interrupt.

## Test plan
- Reset, then read STATUS -> `dat_o`=32'h0000_0001, `ack` exactly 1 cycle after accept, `cmd_valid_o`=0.
- Write CMD 0xA5A5_0001/0002/0003 with `enable`=0, then set CTRL=0x3 with `cmd_ready_i`=1:
  - Stream delivers the three words in order on consecutive cycles.
  - `irq_o` rises 2 cycles after the last pop.
  - Writing IRQ=1 clears it.
- With `FIFO_DEPTH`=4 and `cmd_ready_i`=0, push 5 words -> STATUS=0x0000_1042; the 5th word is absent from the stream.
- With the FIFO full, push in the same cycle as a pop -> `level` stays 4; `overflow` unchanged.
- CMD write with `sel`=4'h3, and a write at `BASE_ADDR`+0x1000 -> both acked, `level` unchanged; the out-of-window read returns 0.
- Assert `wb_rst_i` during an ack-pending write to CTRL -> no ack, CTRL reads 0 after reset.
